// File: rtl/wb2reg_pkg.sv
// rtl/wb2reg_pkg.sv - shared types and helpers for the Wishbone-to-register-bus responder
package wb2reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  function automatic int cnt_width(input int tmo_cyc);
    return $clog2(tmo_cyc + 1);
  endfunction

endpackage

// File: rtl/wb2reg_resp.sv
// rtl/wb2reg_resp.sv - Wishbone classic slave driving a reg_cs/reg_ack register bus
// Optional macro WB2REG_TIMEOUT_EN adds a hung-access timeout error.
module wb2reg_resp
  import wb2reg_pkg::*;
#(
  parameter int          AW        = 24,
  parameter int          TMO_CYC   = 255,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEF
) (
  input  logic          mclk,
  input  logic          reset,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_dat_i,
  output logic [31:0]   wbs_dat_o,
  output logic          wbs_ack_o,
  output logic          wbs_err_o,
  output logic          reg_cs,
  output logic          reg_wr,
  output logic [AW-1:0] reg_addr,
  output logic [3:0]    reg_be,
  output logic [31:0]   reg_wdata,
  input  logic [31:0]   reg_rdata,
  input  logic          reg_ack
);

  state_t          state, state_n;
  logic            err_flag, err_n;
  logic            cs_n, wr_n;
  logic [AW-1:0]   addr_n;
  logic [3:0]      be_n;
  logic [31:0]     wdata_n, dato_n;

`ifdef WB2REG_TIMEOUT_EN
  localparam int CW = cnt_width(TMO_CYC);
  logic [CW-1:0] cnt, cnt_n;
`endif

  // Terminations are decoded from state so they can never appear outside RESP.
  assign wbs_ack_o = (state == RESP) && !err_flag;
  assign wbs_err_o = (state == RESP) && err_flag;

  always_ff @(posedge mclk) begin
    if (reset) begin
      state     <= IDLE;
      err_flag  <= 1'b0;
      reg_cs    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_be    <= '0;
      reg_wdata <= '0;
      wbs_dat_o <= '0;
`ifdef WB2REG_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      state     <= state_n;
      err_flag  <= err_n;
      reg_cs    <= cs_n;
      reg_wr    <= wr_n;
      reg_addr  <= addr_n;
      reg_be    <= be_n;
      reg_wdata <= wdata_n;
      wbs_dat_o <= dato_n;
`ifdef WB2REG_TIMEOUT_EN
      cnt       <= cnt_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    err_n   = err_flag;
    cs_n    = reg_cs;
    wr_n    = reg_wr;
    addr_n  = reg_addr;
    be_n    = reg_be;
    wdata_n = reg_wdata;
    dato_n  = wbs_dat_o;
`ifdef WB2REG_TIMEOUT_EN
    cnt_n   = cnt;
`endif
    case (state)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          wr_n    = wbs_we_i;
          addr_n  = wbs_adr_i[AW-1:0];
          be_n    = wbs_sel_i;
          wdata_n = wbs_dat_i;
          if (|wbs_adr_i[31:AW]) begin
            state_n = RESP;
            err_n   = 1'b1;
            cs_n    = 1'b0;
            if (!wbs_we_i) dato_n = ERR_RDATA;
          end else begin
            state_n = REQ;
            err_n   = 1'b0;
            cs_n    = 1'b1;
          end
        end
      end
      REQ: begin
        // Abort beats a same-cycle reg_ack; ack beats a same-cycle timeout.
        if (!wbs_cyc_i) begin
          state_n = IDLE;
          cs_n    = 1'b0;
`ifdef WB2REG_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end else if (reg_ack) begin
          state_n = RESP;
          err_n   = 1'b0;
          cs_n    = 1'b0;
          if (!reg_wr) dato_n = reg_rdata;
        end
`ifdef WB2REG_TIMEOUT_EN
        else if (cnt == CW'(TMO_CYC - 1)) begin
          state_n = RESP;
          err_n   = 1'b1;
          cs_n    = 1'b0;
          if (!reg_wr) dato_n = ERR_RDATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
`endif
      end
      RESP: begin
        state_n = IDLE;
`ifdef WB2REG_TIMEOUT_EN
        cnt_n   = '0;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb2reg_resp.sv
// tb/tb_wb2reg_resp.sv - scoreboard bench for wb2reg_resp
module tb_wb2reg_resp;
  import wb2reg_pkg::*;

  localparam int AW = 24;

  logic          mclk = 1'b0;
  logic          reset = 1'b1;
  logic          wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [31:0]   wbs_adr_i = '0, wbs_dat_i = '0;
  logic [3:0]    wbs_sel_i = '0;
  logic [31:0]   wbs_dat_o;
  logic          wbs_ack_o, wbs_err_o;
  logic          reg_cs, reg_wr;
  logic [AW-1:0] reg_addr;
  logic [3:0]    reg_be;
  logic [31:0]   reg_wdata;
  logic [31:0]   reg_rdata = '0;
  logic          reg_ack = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        err;
    logic        chk;
    logic [31:0] dat;
  } exp_t;
  exp_t sb[$];

  logic [31:0] exp_dat;

  wb2reg_resp #(.AW(AW), .TMO_CYC(8), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .mclk(mclk), .reset(reset),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_adr_i(wbs_adr_i),
    .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
    .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_be(reg_be),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ack(reg_ack)
  );

  always #5 mclk = ~mclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic wb_drive(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                          input logic [31:0] dat);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_adr_i = adr;
    wbs_we_i  = we;
    wbs_sel_i = sel;
    wbs_dat_i = dat;
  endtask

  task automatic wb_idle();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
  endtask

  task automatic push_exp(input logic err, input logic chk, input logic [31:0] dat);
    exp_t e;
    e.err = err;
    e.chk = chk;
    e.dat = dat;
    sb.push_back(e);
  endtask

  // Every termination the DUT produces must match the oldest expected response.
  always @(negedge mclk) begin : monitor
    exp_t e;
    if (!reset && (wbs_ack_o || wbs_err_o)) begin
      check_eq("ack_err_excl", {31'd0, wbs_ack_o & wbs_err_o}, 32'd0);
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_term", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("sb_err", {31'd0, wbs_err_o}, {31'd0, e.err});
        check_eq("sb_ack", {31'd0, wbs_ack_o}, {31'd0, !e.err});
        if (e.chk) check_eq("sb_dat", wbs_dat_o, e.dat);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_dat = 32'd0;
    repeat (3) tick();
    check_eq("rst_cs", {31'd0, reg_cs}, 32'd0);
    check_eq("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
    check_eq("rst_err", {31'd0, wbs_err_o}, 32'd0);
    check_eq("rst_dat", wbs_dat_o, 32'd0);
    check_eq("rst_addr", {8'd0, reg_addr}, 32'd0);
    reset = 1'b0;
    tick();

    // Write, acked one cycle after reg_cs
    wb_drive(32'h0000_0010, 1'b1, 4'b0011, 32'h1234_5678);
    push_exp(1'b0, 1'b1, exp_dat);
    tick();
    check_eq("wr_cs", {31'd0, reg_cs}, 32'd1);
    check_eq("wr_wr", {31'd0, reg_wr}, 32'd1);
    check_eq("wr_addr", {8'd0, reg_addr}, 32'h10);
    check_eq("wr_be", {28'd0, reg_be}, 32'h3);
    check_eq("wr_wdata", reg_wdata, 32'h1234_5678);
    check_eq("wr_ack_early", {31'd0, wbs_ack_o}, 32'd0);
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    wb_idle();
    check_eq("wr_ack", {31'd0, wbs_ack_o}, 32'd1);
    check_eq("wr_cs_drop", {31'd0, reg_cs}, 32'd0);
    tick();
    check_eq("wr_ack_1cyc", {31'd0, wbs_ack_o}, 32'd0);

    // Read, reg_cs high for exactly 5 cycles
    wb_drive(32'h0000_0004, 1'b0, 4'hF, 32'h0);
    exp_dat = 32'hCAFE_F00D;
    push_exp(1'b0, 1'b1, exp_dat);
    tick();
    for (int i = 1; i < 5; i++) begin
      check_eq("rd_cs_hold", {31'd0, reg_cs}, 32'd1);
      tick();
    end
    check_eq("rd_cs_hold", {31'd0, reg_cs}, 32'd1);
    check_eq("rd_addr", {8'd0, reg_addr}, 32'h4);
    reg_ack = 1'b1;
    reg_rdata = 32'hCAFE_F00D;
    tick();
    reg_ack = 1'b0;
    wb_idle();
    check_eq("rd_cs_drop", {31'd0, reg_cs}, 32'd0);
    check_eq("rd_ack", {31'd0, wbs_ack_o}, 32'd1);
    check_eq("rd_dat", wbs_dat_o, 32'hCAFE_F00D);
    tick();

    // Out-of-range read: decode error in one cycle
    wb_drive(32'h0100_0000, 1'b0, 4'hF, 32'h0);
    exp_dat = 32'hDEAD_BEEF;
    push_exp(1'b1, 1'b1, exp_dat);
    tick();
    wb_idle();
    check_eq("dec_cs", {31'd0, reg_cs}, 32'd0);
    check_eq("dec_err", {31'd0, wbs_err_o}, 32'd1);
    check_eq("dec_dat", wbs_dat_o, 32'hDEAD_BEEF);
    tick();
    check_eq("dec_err_1cyc", {31'd0, wbs_err_o}, 32'd0);

`ifdef WB2REG_TIMEOUT_EN
    // Hung access: reg_cs for TMO_CYC cycles then an error
    wb_drive(32'h0000_0008, 1'b0, 4'hF, 32'h0);
    push_exp(1'b1, 1'b1, 32'hDEAD_BEEF);
    tick();
    for (int i = 1; i < 8; i++) begin
      check_eq("tmo_cs_hold", {31'd0, reg_cs}, 32'd1);
      tick();
    end
    check_eq("tmo_cs_hold", {31'd0, reg_cs}, 32'd1);
    tick();
    wb_idle();
    check_eq("tmo_cs_drop", {31'd0, reg_cs}, 32'd0);
    check_eq("tmo_err", {31'd0, wbs_err_o}, 32'd1);
    tick();
`else
    // No timeout: reg_cs stays up until the master gives up
    wb_drive(32'h0000_0008, 1'b0, 4'hF, 32'h0);
    tick();
    for (int i = 0; i < 20; i++) begin
      check_eq("notmo_cs_hold", {31'd0, reg_cs}, 32'd1);
      tick();
    end
    wb_idle();
    tick();
    check_eq("notmo_cs_drop", {31'd0, reg_cs}, 32'd0);
    tick();
`endif

    // Next transaction completes normally
    wb_drive(32'h0000_0014, 1'b1, 4'hF, 32'hA5A5_5A5A);
    push_exp(1'b0, 1'b1, exp_dat);
    tick();
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    wb_idle();
    check_eq("post_ack", {31'd0, wbs_ack_o}, 32'd1);
    tick();

    // Master abort two cycles into REQ, with a late reg_ack
    reg_rdata = 32'h7777_1111;
    wb_drive(32'h0000_000C, 1'b0, 4'hF, 32'h0);
    tick();
    tick();
    tick();
    wb_idle();
    reg_ack = 1'b1;
    tick();
    check_eq("abort_cs", {31'd0, reg_cs}, 32'd0);
    check_eq("abort_ack", {31'd0, wbs_ack_o | wbs_err_o}, 32'd0);
    tick();
    reg_ack = 1'b0;
    check_eq("abort_idle_ack", {31'd0, wbs_ack_o | wbs_err_o}, 32'd0);
    check_eq("abort_dat", wbs_dat_o, exp_dat);
    tick();

    // Back-to-back: stb held across the write ack
    wb_drive(32'h0000_0020, 1'b1, 4'b1100, 32'hFEED_0001);
    push_exp(1'b0, 1'b1, exp_dat);
    tick();
    reg_ack = 1'b1;
    tick();
    check_eq("b2b_wr_ack", {31'd0, wbs_ack_o}, 32'd1);
    reg_ack = 1'b0;
    wb_drive(32'h0000_0024, 1'b0, 4'hF, 32'h0);
    exp_dat = 32'h1357_9BDF;
    push_exp(1'b0, 1'b1, exp_dat);
    tick();
    check_eq("b2b_gap_cs", {31'd0, reg_cs}, 32'd0);
    tick();
    check_eq("b2b_rd_cs", {31'd0, reg_cs}, 32'd1);
    check_eq("b2b_rd_wr", {31'd0, reg_wr}, 32'd0);
    check_eq("b2b_rd_addr", {8'd0, reg_addr}, 32'h24);
    reg_ack = 1'b1;
    reg_rdata = 32'h1357_9BDF;
    tick();
    reg_ack = 1'b0;
    wb_idle();
    check_eq("b2b_rd_dat", wbs_dat_o, 32'h1357_9BDF);
    tick();

    // Reset in the middle of REQ
    wb_drive(32'h0000_0030, 1'b1, 4'hF, 32'h5555_AAAA);
    tick();
    check_eq("rstreq_cs_pre", {31'd0, reg_cs}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wb_idle();
    check_eq("rstreq_cs", {31'd0, reg_cs}, 32'd0);
    check_eq("rstreq_term", {31'd0, wbs_ack_o | wbs_err_o}, 32'd0);
    check_eq("rstreq_dat", wbs_dat_o, 32'd0);
    check_eq("rstreq_wdata", reg_wdata, 32'd0);
    repeat (3) tick();

    check_eq("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb2reg_resp.md
Name: wb2reg_resp

Overview:
- Wishbone classic slave that converts single Wishbone cycles into the register-bus handshake used by QSPI-slave and peripheral register blocks: reg_cs/reg_wr/reg_addr/reg_be/reg_wdata out, reg_rdata/reg_ack in.
- Sits on the Wishbone interconnect as the responder, in front of a register file.
- Registers the request, holds it stable until the register block acks, then returns a one-cycle wbs_ack_o or wbs_err_o.
- Detects out-of-range addresses and hung register accesses.

Parameters:
- AW, 24, register address width; wbs_adr_i[31:AW] must be zero.
- TMO_CYC, 255, maximum REQ-state cycles before a timeout error; must be ≥ 1.
- ERR_RDATA, 32'hDEAD_BEEF, value returned on wbs_dat_o for an errored read.

Ports:
- mclk  in  1  clock
- reset  in  1  synchronous active-high reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_adr_i  in  32  byte address
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte select
- wbs_dat_i  in  32  write data
- wbs_dat_o  out  32  read data
- wbs_ack_o  out  1  normal termination
- wbs_err_o  out  1  error termination
- reg_cs  out  1  register access request
- reg_wr  out  1  1 = write, 0 = read
- reg_addr  out  AW  register address
- reg_be  out  4  byte enables
- reg_wdata  out  32  write data
- reg_rdata  in  32  read data, valid with reg_ack
- reg_ack  in  1  access complete

Behaviour:
- Single clock mclk. Reset is synchronous and active-high on reset.
- Reset values: all outputs 0. wbs_dat_o = 0. State = IDLE. Timeout counter = 0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - On wbs_cyc_i & wbs_stb_i, latch adr[AW-1:0], we, sel and dat into the reg_* output registers.
  - If wbs_adr_i[31:AW] != 0, go to RESP with err_flag = 1 and reg_cs kept 0; a read returns ERR_RDATA.
  - Otherwise go to REQ with reg_cs = 1.
- REQ:
  - reg_cs = 1; reg_addr, reg_be, reg_wr and reg_wdata held constant.
  - reg_ack = 1: drop reg_cs. On a read, capture reg_rdata into wbs_dat_o. Go to RESP with err_flag = 0.
  - Counter increments each REQ cycle without reg_ack. At count == TMO_CYC-1 with no reg_ack: drop reg_cs, wbs_dat_o = ERR_RDATA if read, go to RESP with err_flag = 1.
  - reg_ack and timeout in the same cycle: reg_ack wins.
  - wbs_cyc_i falls while in REQ (master abort): drop reg_cs, go to IDLE, no ack/err, wbs_dat_o unchanged, reg_ack that cycle ignored.
- RESP:
  - wbs_ack_o = !err_flag and wbs_err_o = err_flag, for exactly one cycle.
  - Counter cleared; next state IDLE unconditionally.
- Latency:
  - stb sampled at edge 0 gives reg_cs at edge 0+.
  - Earliest reg_ack is sampled at edge 1, giving wbs_ack_o high in the cycle after edge 1: 2 cycles minimum.
  - Decode error: wbs_err_o in the cycle after edge 0, i.e. 1 cycle.
- Back-to-back: stb still high in IDLE after RESP is treated as a new transaction. Peak throughput is one access per 3 cycles.
- wbs_ack_o and wbs_err_o are never high together and never high outside RESP.
- reg_ack in IDLE or RESP is ignored.
- wbs_dat_o changes only on read completion or errored read; writes do not modify it.
- Reset mid-REQ: reg_cs deasserted on the reset edge, no ack issued.

Optional Feature:
- Macro: WB2REG_TIMEOUT_EN.
- Defined: timeout counter and timeout error as described above.
- Undefined: no counter logic; REQ waits indefinitely for reg_ack or a master abort. wbs_err_o is raised only for decode errors.

Decomposition:
- Package wb2reg_pkg contains:
  - state enum typedef (IDLE, REQ, RESP), 2 bits;
  - localparam ERR_RDATA default;
  - function computing the counter width, $clog2(TMO_CYC+1).
- Single flat module; no sub-module needed. The timeout counter is small and stays inline under the ifdef.

Test Plan:
- Write adr=0x0000_0010, sel=4'b0011, dat=0x1234_5678; register block acks 1 cycle after reg_cs -> reg_wr=1, reg_addr=0x10, reg_be=3, reg_wdata=0x12345678; one-cycle wbs_ack_o 2 cycles after stb; wbs_err_o=0.
- Read adr=0x0000_0004; reg_rdata=0xCAFE_F00D with reg_ack after 5 cycles -> wbs_dat_o=0xCAFEF00D, wbs_ack_o one cycle, reg_cs high exactly 5 cycles.
- Read adr=0x0100_0000 (bit 24 set, AW=24) -> reg_cs never asserts; wbs_err_o one cycle; wbs_dat_o=0xDEADBEEF.
- WB2REG_TIMEOUT_EN defined, TMO_CYC=8, reg_ack never asserted -> reg_cs high 8 cycles, then wbs_err_o one cycle; next transaction completes normally.
- Master drops wbs_cyc_i 2 cycles into REQ -> reg_cs falls the next cycle; no ack/err; a late reg_ack is ignored; FSM returns to IDLE.
- Back-to-back write then read with stb held across ack, plus reset asserted during REQ -> second access is issued in IDLE after RESP; after reset, all outputs are 0 the cycle after.
